// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the spectrum path: fills a sample frame, runs the FFT, triggers drawing, and flips the bank on vsync.
// Optional feature: define FFT_SEQ_OVERLAP_EN for 50% frame overlap between consecutive FFTs.
module fft_frame_sequencer #(
  parameter int N_PTS    = 16,
  parameter int SAMPLE_W = 12,
  parameter int DATA_W   = 36,
  parameter int TIMEOUT  = 1024
) (
  input  logic                           in_clock,
  input  logic                           reset,
  input  logic                           sample_valid,
  input  logic signed [SAMPLE_W-1:0]     sample_data,
  output logic [N_PTS-1:0][DATA_W-1:0]   frame_out,
  output logic                           fft_start,
  input  logic                           fft_done,
  output logic                           draw_start,
  input  logic                           draw_done,
  input  logic                           vsync,
  output logic                           bank_sel,
  output logic                           busy,
  output logic                           overrun,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(N_PTS);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int HALF  = N_PTS / 2;

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_WAIT_FFT,
    S_DRAW,
    S_WAIT_VSYNC
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              wr_idx_q, wr_idx_d;
  logic [TO_W-1:0]               to_cnt_q, to_cnt_d;
  logic                          vsync_q;
  logic [N_PTS-1:0][DATA_W-1:0]  frame_q, frame_d;
  logic                          fft_start_q, fft_start_d;
  logic                          draw_start_q, draw_start_d;
  logic                          bank_sel_q, bank_sel_d;
  logic                          busy_q, busy_d;
  logic                          overrun_q, overrun_d;
  logic                          timeout_err_q, timeout_err_d;

  function automatic logic [DATA_W-1:0] sign_ext(input logic signed [SAMPLE_W-1:0] s);
    return DATA_W'(s);
  endfunction

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    to_cnt_d      = to_cnt_q;
    frame_d       = frame_q;
    fft_start_d   = 1'b0;
    draw_start_d  = 1'b0;
    bank_sel_d    = bank_sel_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_FILL: begin
        if (sample_valid) begin
          frame_d[wr_idx_q] = sign_ext(sample_data);
          if (wr_idx_q == IDX_W'(N_PTS-1)) begin
            wr_idx_d    = '0;
            state_d     = S_START;
            fft_start_d = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_FFT;
      end
      S_WAIT_FFT: begin
        // A done arriving on the final timeout cycle still counts as success.
        if (fft_done) begin
          state_d      = S_DRAW;
          draw_start_d = 1'b1;
        end else if (to_cnt_q == TO_W'(TIMEOUT-1)) begin
          timeout_err_d = 1'b1;
          wr_idx_d      = '0;
          state_d       = S_FILL;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DRAW: begin
        if (draw_done) state_d = S_WAIT_VSYNC;
      end
      S_WAIT_VSYNC: begin
        if (vsync_q && !vsync) begin
          bank_sel_d = ~bank_sel_q;
          state_d    = S_FILL;
`ifdef FFT_SEQ_OVERLAP_EN
          for (int i = 0; i < HALF; i++) frame_d[i] = frame_q[i+HALF];
          wr_idx_d = IDX_W'(HALF);
`else
          wr_idx_d = '0;
`endif
        end
      end
      default: state_d = S_FILL;
    endcase

    if (sample_valid && (state_q != S_FILL)) overrun_d = 1'b1;
    busy_d = (state_d != S_FILL);
  end

  always_ff @(posedge in_clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FILL;
      wr_idx_q      <= '0;
      to_cnt_q      <= '0;
      vsync_q       <= 1'b1;
      frame_q       <= '0;
      fft_start_q   <= 1'b0;
      draw_start_q  <= 1'b0;
      bank_sel_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      to_cnt_q      <= to_cnt_d;
      vsync_q       <= vsync;
      frame_q       <= frame_d;
      fft_start_q   <= fft_start_d;
      draw_start_q  <= draw_start_d;
      bank_sel_q    <= bank_sel_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign frame_out   = frame_q;
  assign fft_start   = fft_start_q;
  assign draw_start  = draw_start_q;
  assign bank_sel    = bank_sel_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
